// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED event scheduler:
//   - state_t   : scheduler FSM state encoding (IDLE / SHOW / GAP)
//   - COLOR_W   : width of one requester's colour pattern
//   - OFS_*     : bit positions of each LED drive inside a colour slice,
//                 slice layout is {led1_r, led1_g, led1_b, led0_r, led0_g, led0_b}
//   - clog2_min1: width helper that never returns 0
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int COLOR_W = 6;

    localparam int OFS_LED0_B = 0;
    localparam int OFS_LED0_G = 1;
    localparam int OFS_LED0_R = 2;
    localparam int OFS_LED1_B = 3;
    localparam int OFS_LED1_G = 4;
    localparam int OFS_LED1_R = 5;

    // Bits needed to index/count n values, at least 1 so buses never collapse.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// -----------------------------------------------------------------------------
// led_pwm_gen
// Free-running PWM tick source. The counter runs 0..PWM_TICKS and wraps, so
// the period is PWM_TICKS+1 cycles; o_pulse is high for the single cycle in
// which the count equals PWM_TICKS.
// Ports:
//   i_clock  in   clock, rising edge
//   i_reset  in   synchronous, active-high reset (count -> 0)
//   o_pulse  out  one-cycle pulse per PWM period
// -----------------------------------------------------------------------------
module led_pwm_gen #(
    parameter int PWM_TICKS = 50
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_pulse
);

    localparam int                CNT_W = (PWM_TICKS < 1) ? 1 : $clog2(PWM_TICKS + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PWM_TICKS);

    logic [CNT_W-1:0] r_count;

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_pulse = (r_count == LAST);

endmodule

// File: rtl/led_event_sched.sv
// -----------------------------------------------------------------------------
// led_event_sched
// Fixed-priority scheduler that lends a pair of RGB LEDs to one requester at a
// time. A granted requester's colour is shown (PWM-dimmed) for HOLD_TICKS
// cycles, followed by GAP_TICKS blank cycles, before arbitration reopens.
// Index 0 has the highest priority; requests are levels and are not queued.
//
// Build option: define LED_PREEMPT_EN to let a higher-priority (lower index)
// request take over a slot that is still in SHOW. Default build: no preemption.
//
// Ports:
//   i_clock            in   clock, rising edge
//   i_reset            in   synchronous, active-high reset
//   i_req[NUM_REQ]     in   level request per requester
//   i_color[6*NUM_REQ] in   colour slice per requester
//   o_grant[NUM_REQ]   out  one-hot, one-cycle acceptance pulse
//   o_owner            out  index of current slot owner (valid while o_busy)
//   o_busy             out  high during SHOW and GAP
//   o_led0_*/o_led1_*  out  registered LED drives
// -----------------------------------------------------------------------------
module led_event_sched
    import led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HOLD_TICKS = 100000000,
    parameter int GAP_TICKS  = 10000000,
    parameter int PWM_TICKS  = 50
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [COLOR_W*NUM_REQ-1:0]   i_color,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [clog2_min1(NUM_REQ)-1:0] o_owner,
    output logic                         o_busy,
    output logic                         o_led0_r,
    output logic                         o_led0_g,
    output logic                         o_led0_b,
    output logic                         o_led1_r,
    output logic                         o_led1_g,
    output logic                         o_led1_b
);

    localparam int OWN_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1((HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [OWN_W-1:0]     r_owner;
    logic [COLOR_W-1:0]   r_color;
    logic [NUM_REQ-1:0]   r_grant;
    logic [COLOR_W-1:0]   r_led;
    logic                 r_busy;

    logic                 w_pulse;
    logic                 w_any;
    logic [OWN_W-1:0]     w_idx;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [COLOR_W-1:0]   w_slice;
    logic                 w_preempt;
    logic                 w_take;

    led_pwm_gen #(
        .PWM_TICKS (PWM_TICKS)
    ) u_pwm (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_pulse (w_pulse)
    );

    // Lowest asserted index wins: scan downwards so the last hit is the lowest.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_any    = 1'b0;
        w_idx    = '0;
        w_onehot = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_any = 1'b1;
                w_idx = OWN_W'(k);
            end
        end
        w_onehot[w_idx] = w_any;
    end

    assign w_slice = i_color[w_idx*COLOR_W +: COLOR_W];

`ifdef LED_PREEMPT_EN
    assign w_preempt = (r_state == SHOW) && w_any && (w_idx < r_owner);
`else
    assign w_preempt = 1'b0;
`endif

    // A new slot starts either from IDLE or by preempting a SHOW slot.
    assign w_take = ((r_state == IDLE) && w_any) || w_preempt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_owner <= '0;
            r_color <= '0;
            r_grant <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= '0;
            r_led   <= '0;
            if (w_take) begin
                r_state <= SHOW;
                r_count <= HOLD_LOAD;
                r_owner <= w_idx;
                r_color <= w_slice;
                r_grant <= w_onehot;
                r_led   <= w_slice & {COLOR_W{w_pulse}};
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    SHOW: begin
                        if (r_count == '0) begin
                            if (GAP_TICKS > 0) begin
                                r_state <= GAP;
                                r_count <= GAP_LOAD;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_count <= r_count - 1'b1;
                            r_led   <= r_color & {COLOR_W{w_pulse}};
                        end
                    end
                    GAP: begin
                        if (r_count == '0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_grant  = r_grant;
    assign o_owner  = r_owner;
    assign o_busy   = r_busy;
    assign o_led0_b = r_led[OFS_LED0_B];
    assign o_led0_g = r_led[OFS_LED0_G];
    assign o_led0_r = r_led[OFS_LED0_R];
    assign o_led1_b = r_led[OFS_LED1_B];
    assign o_led1_g = r_led[OFS_LED1_G];
    assign o_led1_r = r_led[OFS_LED1_R];

endmodule

// File: tb/tb_led_event_sched.sv
// -----------------------------------------------------------------------------
// tb_led_event_sched
// Directed scenarios with fixed expectations plus a randomized run compared
// cycle by cycle against a slot-level reference model (remaining SHOW/GAP
// cycle counts and a PWM phase). A second instance with HOLD_TICKS=1 and
// GAP_TICKS=0 covers the no-gap boundary.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_event_sched;

    localparam int NUM_REQ = 4;
    localparam int HOLD    = 10;
    localparam int GAP     = 2;
    localparam int PWM     = 3;
`ifdef LED_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [3:0]  i_req   = '0;
    logic [23:0] i_color = '0;

    logic [3:0]  o_grant;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic        o_led0_r, o_led0_g, o_led0_b, o_led1_r, o_led1_g, o_led1_b;
    logic [5:0]  w_led;

    logic [3:0]  g0_grant;
    logic [1:0]  g0_owner;
    logic        g0_busy;
    logic        g0_led0_r, g0_led0_g, g0_led0_b, g0_led1_r, g0_led1_g, g0_led1_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: slot bookkeeping in remaining-cycle terms.
    int         m_show_left = 0;
    int         m_gap_left  = 0;
    int         m_owner     = 0;
    int         m_phase     = 0;
    logic [5:0] m_color     = '0;
    logic [3:0] exp_grant   = '0;
    logic       exp_busy    = 1'b0;
    logic [5:0] exp_led     = '0;

    always #5 i_clock = ~i_clock;

    assign w_led = {o_led1_r, o_led1_g, o_led1_b, o_led0_r, o_led0_g, o_led0_b};

    led_event_sched #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_TICKS (HOLD),
        .GAP_TICKS  (GAP),
        .PWM_TICKS  (PWM)
    ) u_dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_req    (i_req),
        .i_color  (i_color),
        .o_grant  (o_grant),
        .o_owner  (o_owner),
        .o_busy   (o_busy),
        .o_led0_r (o_led0_r),
        .o_led0_g (o_led0_g),
        .o_led0_b (o_led0_b),
        .o_led1_r (o_led1_r),
        .o_led1_g (o_led1_g),
        .o_led1_b (o_led1_b)
    );

    led_event_sched #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_TICKS (1),
        .GAP_TICKS  (0),
        .PWM_TICKS  (PWM)
    ) u_g0 (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_req    (i_req),
        .i_color  (i_color),
        .o_grant  (g0_grant),
        .o_owner  (g0_owner),
        .o_busy   (g0_busy),
        .o_led0_r (g0_led0_r),
        .o_led0_g (g0_led0_g),
        .o_led0_b (g0_led0_b),
        .o_led1_r (g0_led1_r),
        .o_led1_g (g0_led1_g),
        .o_led1_b (g0_led1_b)
    );

    function automatic int lowest(input logic [3:0] r);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[k]) return k;
        end
        return -1;
    endfunction

    // Expected outputs for the cycle following this edge.
    task automatic model_edge();
        int j;
        bit pulse;
        j = lowest(i_req);
        exp_grant = '0;
        if (i_reset) begin
            m_show_left = 0;
            m_gap_left  = 0;
            m_owner     = 0;
            m_phase     = 0;
            m_color     = '0;
            exp_busy    = 1'b0;
            exp_led     = '0;
            return;
        end
        pulse   = (m_phase == PWM);
        m_phase = (m_phase + 1) % (PWM + 1);
        if (m_show_left > 0) begin
            if (PREEMPT && j >= 0 && j < m_owner) begin
                m_owner      = j;
                m_color      = i_color[j*6 +: 6];
                m_show_left  = HOLD;
                exp_grant[j] = 1'b1;
            end else begin
                m_show_left--;
                if (m_show_left == 0) m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (j >= 0) begin
            m_owner      = j;
            m_color      = i_color[j*6 +: 6];
            m_show_left  = HOLD;
            exp_grant[j] = 1'b1;
        end
        exp_busy = (m_show_left > 0) || (m_gap_left > 0);
        exp_led  = (m_show_left > 0 && pulse) ? m_color : 6'd0;
    endtask

    task automatic tick();
        @(posedge i_clock);
        model_edge();
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", o_busy, n);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req   = 4'b1111;
        i_color = 24'($urandom);
        tick();
        tick();
        n_checks++;
        if (o_grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b expected 0000", o_grant); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_checks++;
        if (w_led !== 6'd0) begin n_errors++; $display("FAIL reset_led: got %b expected 000000", w_led); end
        i_reset = 1'b0;
        i_req   = 4'b0000;
    endtask

    task automatic test_single();
        int busy_cnt, hits, last_hit, bad, gap_led;
        busy_cnt = 0; hits = 0; last_hit = 0; bad = 0; gap_led = 0;
        i_color = 24'($urandom);
        i_color[17:12] = 6'b000111;
        i_req = 4'b0100;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (o_grant !== 4'b0100) begin n_errors++; $display("FAIL single_grant: got %b expected 0100", o_grant); end
                n_checks++;
                if (o_owner !== 2'd2) begin n_errors++; $display("FAIL single_owner: got %0d expected 2", o_owner); end
                i_req = 4'b0000;
            end
            if (c == 2) begin
                n_checks++;
                if (o_grant !== 4'b0000) begin n_errors++; $display("FAIL single_grant_pulse: got %b expected 0000", o_grant); end
            end
            if (o_busy === 1'b1) busy_cnt++;
            if (c <= 10 && w_led !== 6'd0) begin
                if (w_led !== 6'b000111) bad++;
                if (last_hit > 0 && c - last_hit != 4) bad++;
                last_hit = c;
                hits++;
            end
            if (c > 10 && w_led !== 6'd0) gap_led++;
            if (c == 13) begin
                n_checks++;
                if (o_busy !== 1'b0) begin n_errors++; $display("FAIL single_end_busy: got %b expected 0", o_busy); end
            end
            // Colour changes after acceptance must not reach the LEDs.
            i_color = 24'($urandom);
        end
        n_checks++;
        if (busy_cnt != 12) begin n_errors++; $display("FAIL single_busy_len: got %0d expected 12", busy_cnt); end
        n_checks++;
        if (hits < 2 || hits > 3) begin n_errors++; $display("FAIL single_pwm_hits: got %0d expected 2..3", hits); end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL single_pwm_shape: got %0d bad pulses expected 0", bad); end
        n_checks++;
        if (gap_led != 0) begin n_errors++; $display("FAIL single_gap_led: got %0d lit gap cycles expected 0", gap_led); end
    endtask

    task automatic test_simultaneous();
        i_color = 24'($urandom);
        i_req   = 4'b1010;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (o_grant !== 4'b0010) begin n_errors++; $display("FAIL simul_grant: got %b expected 0010", o_grant); end
                n_checks++;
                if (o_owner !== 2'd1) begin n_errors++; $display("FAIL simul_owner: got %0d expected 1", o_owner); end
                i_req = 4'b1000;
            end
            if (c == 13) begin
                n_checks++;
                if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL simul_idle: got grant %b busy %b expected 0000/0", o_grant, o_busy);
                end
            end
            if (c == 14) begin
                n_checks++;
                if (o_grant !== 4'b1000) begin n_errors++; $display("FAIL simul_regrant: got %b expected 1000", o_grant); end
                n_checks++;
                if (o_owner !== 2'd3) begin n_errors++; $display("FAIL simul_reowner: got %0d expected 3", o_owner); end
                i_req = 4'b0000;
            end
        end
        wait_idle();
    endtask

    task automatic test_preempt();
        int stray;
        stray = 0;
        i_color = 24'($urandom);
        i_req   = 4'b0100;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (o_grant !== 4'b0100) begin n_errors++; $display("FAIL preempt_first_grant: got %b expected 0100", o_grant); end
                i_req = 4'b0000;
            end
            if (c == 4) i_req = 4'b0001;
`ifdef LED_PREEMPT_EN
            if (c == 5) begin
                n_checks++;
                if (o_grant !== 4'b0001) begin n_errors++; $display("FAIL preempt_grant: got %b expected 0001", o_grant); end
                n_checks++;
                if (o_owner !== 2'd0) begin n_errors++; $display("FAIL preempt_owner: got %0d expected 0", o_owner); end
                i_req = 4'b0000;
            end else if (c > 5 && o_grant !== 4'b0000) begin
                stray++;
            end
            if (c == 16) begin
                n_checks++;
                if (o_busy !== 1'b1) begin n_errors++; $display("FAIL preempt_slot_len: got busy %b expected 1", o_busy); end
            end
            if (c == 17) begin
                n_checks++;
                if (o_busy !== 1'b0) begin n_errors++; $display("FAIL preempt_slot_end: got busy %b expected 0", o_busy); end
            end
`else
            if (c >= 5 && c <= 13 && o_grant !== 4'b0000) stray++;
            if (c == 13) begin
                n_checks++;
                if (o_busy !== 1'b0) begin n_errors++; $display("FAIL nopreempt_idle: got busy %b expected 0", o_busy); end
            end
            if (c == 14) begin
                n_checks++;
                if (o_grant !== 4'b0001) begin n_errors++; $display("FAIL nopreempt_grant: got %b expected 0001", o_grant); end
                n_checks++;
                if (o_owner !== 2'd0) begin n_errors++; $display("FAIL nopreempt_owner: got %0d expected 0", o_owner); end
                i_req = 4'b0000;
            end
`endif
        end
        n_checks++;
        if (stray != 0) begin n_errors++; $display("FAIL preempt_stray_grant: got %0d extra grants expected 0", stray); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        i_color = 24'($urandom);
        i_req   = 4'b0010;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (o_grant !== 4'b0010) begin n_errors++; $display("FAIL rstmid_grant: got %b expected 0010", o_grant); end
            end
            if (c == 5) i_reset = 1'b1;
            if (c == 6) begin
                n_checks++;
                if (o_busy !== 1'b0 || w_led !== 6'd0 || o_grant !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL rstmid_outputs: got busy %b led %b grant %b expected 0/000000/0000", o_busy, w_led, o_grant);
                end
                i_reset = 1'b0;
            end
            if (c == 7) begin
                n_checks++;
                if (o_grant !== 4'b0010 || o_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rstmid_idle_accept: got grant %b busy %b expected 0010/1", o_grant, o_busy);
                end
                i_req = 4'b0000;
            end
        end
        wait_idle();
    endtask

    task automatic test_early_drop();
        int busy_cnt, gap_led;
        busy_cnt = 0; gap_led = 0;
        i_color = 24'($urandom);
        i_req   = 4'b0010;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (o_grant !== 4'b0010) begin n_errors++; $display("FAIL drop_grant: got %b expected 0010", o_grant); end
            end
            if (c == 2) i_req = 4'b0000;
            if (o_busy === 1'b1) busy_cnt++;
            if ((c == 11 || c == 12) && w_led !== 6'd0) gap_led++;
        end
        n_checks++;
        if (busy_cnt != 12) begin n_errors++; $display("FAIL drop_busy_len: got %0d expected 12", busy_cnt); end
        n_checks++;
        if (gap_led != 0) begin n_errors++; $display("FAIL drop_gap_led: got %0d expected 0", gap_led); end
    endtask

    task automatic test_gap_zero();
        i_color = 24'($urandom);
        i_req   = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_checks++;
            if (c % 2 == 1) begin
                if (g0_grant !== 4'b0001 || g0_busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL gap0_cycle%0d: got grant %b busy %b expected 0001/1", c, g0_grant, g0_busy);
                end
            end else begin
                if (g0_grant !== 4'b0000 || g0_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gap0_cycle%0d: got grant %b busy %b expected 0000/0", c, g0_grant, g0_busy);
                end
            end
        end
        i_req = 4'b0000;
        wait_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < NUM_REQ; k++) i_req[k] = ($urandom_range(0, 3) == 0);
            end
            i_color = 24'($urandom);
            i_reset = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++;
            if (o_grant !== exp_grant) begin n_errors++; $display("FAIL rand_grant c%0d: got %b expected %b", c, o_grant, exp_grant); end
            n_checks++;
            if (o_busy !== exp_busy) begin n_errors++; $display("FAIL rand_busy c%0d: got %b expected %b", c, o_busy, exp_busy); end
            n_checks++;
            if (w_led !== exp_led) begin n_errors++; $display("FAIL rand_led c%0d: got %b expected %b", c, w_led, exp_led); end
            if (exp_busy) begin
                n_checks++;
                if (o_owner !== 2'(m_owner)) begin n_errors++; $display("FAIL rand_owner c%0d: got %0d expected %0d", c, o_owner, m_owner); end
            end
        end
        i_reset = 1'b0;
        i_req   = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_preempt();
        test_reset_mid();
        test_early_drop();
        test_gap_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_event_sched.md
LED_EVENT_SCHED -- requirements
Module: led_event_sched

Interface
- REQ-001: Parameter NUM_REQ, default 4; number of requesters. Index 0 has the highest priority.
- REQ-002: Parameter HOLD_TICKS, default 100000000; number of clock cycles a granted pattern is shown (1 s at 100 MHz).
- REQ-003: Parameter GAP_TICKS, default 10000000; number of blank cycles between two slots.
- REQ-004: Parameter PWM_TICKS, default 50; the PWM period is PWM_TICKS+1 cycles.
- REQ-005: i_clock  in  1  clock; all logic is on its rising edge.
- REQ-006: i_reset  in  1  reset, synchronous, active-high.
- REQ-007: i_req  in  NUM_REQ  level request, one bit per requester.
- REQ-008: i_color  in  6*NUM_REQ  pattern per requester; slice k is {led1_r,led1_g,led1_b,led0_r,led0_g,led0_b}.
- REQ-009: o_grant  out  NUM_REQ  one-hot, one-cycle pulse marking acceptance of a request.
- REQ-010: o_owner  out  clog2(NUM_REQ)  index of the current slot owner; valid while o_busy is high.
- REQ-011: o_busy  out  1  high in the SHOW and GAP states.
- REQ-012: o_led0_r, o_led0_g, o_led0_b, o_led1_r, o_led1_g, o_led1_b  out  1 each  registered LED drives.

Function
- REQ-013: The FSM shall have three states: IDLE, SHOW and GAP.
- REQ-014: IDLE: if any i_req bit is high at an edge, the block shall, at that edge:
  - latch the lowest asserted index k as owner;
  - latch color slice k;
  - pulse o_grant[k] for the following cycle;
  - load the hold counter with HOLD_TICKS-1;
  - enter SHOW.
- REQ-015: SHOW: the LED outputs shall equal the latched color ANDed with the PWM pulse, registered one cycle after the pulse.
- REQ-016: SHOW: the hold counter shall decrement once per cycle; at an edge where it equals 0, the block shall load GAP_TICKS-1 and enter GAP. SHOW therefore lasts exactly HOLD_TICKS cycles.
- REQ-017: GAP: all LED outputs shall be 0 and the counter shall decrement; at an edge where it equals 0, the block shall enter IDLE.
- REQ-018: Requests are not queued; a requester still high when the block returns to IDLE re-arbitrates against the others.
- REQ-019: Lowering i_req[k] during its own slot shall not shorten the slot.
- REQ-020: The PWM counter shall run freely from 0 to PWM_TICKS and back to 0; its pulse is high for one cycle at the edge where the count equals PWM_TICKS.
- REQ-021: Color changes on i_color after acceptance shall have no effect until the next grant.
- REQ-022: When GAP_TICKS is 0, the block shall skip GAP and go from SHOW directly to IDLE.

Reset
- REQ-023: On i_reset the block shall:
  - enter IDLE;
  - clear the counters, PWM counter, owner and latched color;
  - drive o_grant, o_busy and all LED outputs to 0 in the next cycle.
- REQ-024: A reset during SHOW or GAP shall abort the slot without issuing a grant pulse.

Configuration
- REQ-025: With LED_PREEMPT_EN defined, a request from an index j lower than the owner, seen at an SHOW edge, shall:
  - take the slot at that edge, as in IDLE (pulse o_grant[j], latch color j);
  - reload the hold counter with HOLD_TICKS-1.
- REQ-026: Preemption shall not apply in GAP.
- REQ-027: Without LED_PREEMPT_EN, a request arriving during SHOW shall wait until the block returns to IDLE.

Structure
- REQ-028: The shared package led_pkg shall hold:
  - the state encoding (IDLE=2'd0, SHOW=2'd1, GAP=2'd2);
  - the color field width (6);
  - the bit offsets within a color slice.
- REQ-029: The PWM counter shall be the sub-module led_pwm_gen, parameterised by PWM_TICKS, with output o_pulse.

Verification (NUM_REQ=4, HOLD_TICKS=10, GAP_TICKS=2, PWM_TICKS=3)
- REQ-030: Single request: i_req=4'b0100 with color 6'b000111 -> o_grant=4'b0100 for one cycle, then o_busy high for 12 cycles. During SHOW, o_led0_r/g/b pulse once every 4 cycles; during GAP, all LEDs are 0.
- REQ-031: Simultaneous requests: i_req=4'b1010 -> o_grant=4'b0010 and o_owner=1. If bit 3 is still held, o_grant=4'b1000 on the cycle after GAP ends.
- REQ-032: Preemption: i_req[2] is granted, then i_req[0] rises in SHOW cycle 4.
  - With LED_PREEMPT_EN: o_grant=4'b0001 on the next cycle, o_owner=0, and a fresh 10-cycle SHOW.
  - Without LED_PREEMPT_EN: there is no grant until IDLE, then o_grant=4'b0001.
- REQ-033: Reset mid-operation: i_reset is pulsed in SHOW cycle 5 -> o_busy, all LEDs and o_grant are 0 on the next cycle, and the state is IDLE.
- REQ-034: Early drop: i_req[1] drops one cycle after its grant -> SHOW still lasts exactly 10 cycles, followed by 2 GAP cycles.
